// File: rtl/planificador_ascensor_pkg.sv
// planificador_ascensor_pkg: shared floor count, widths, state enum and counter-width helper
package planificador_ascensor_pkg;
  localparam int N_FLOORS = 10;
  localparam int FLOOR_W = 4;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
  function automatic int cnt_w(input int a, input int b);
    return $clog2(a > b ? a : b);
  endfunction
endpackage

// File: rtl/planificador_ascensor_buscador.sv
// buscador_solicitudes: (req, floor) -> here/above/below request flags; ports req, floor in, here/above/below out
module buscador_solicitudes
  import planificador_ascensor_pkg::*;
(
  input  logic [N_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]  floor,
  output logic                here,
  output logic                above,
  output logic                below
);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  logic [N_FLOORS-1:0] at;
  assign at = ONE << floor;
  assign here = |(req & at);
  assign above = |(req & ~((at << 1) - ONE));
  assign below = |(req & (at - ONE));
endmodule

// File: rtl/planificador_ascensor.sv
// planificador_ascensor: sweep scheduler; clk, reset (async active-low), req in; floor, motor_up, motor_down, door_open, dir_up, clear out
module planificador_ascensor
  import planificador_ascensor_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]  floor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] clear
);
  localparam int CW = cnt_w(TRAVEL_CYCLES, DOOR_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic [FLOOR_W-1:0] probe;
  logic arrive, decide, restart, here, above, below, ahead, behind, go_up;
  assign arrive = (state == MOVE_UP || state == MOVE_DOWN) && cnt == CW'(TRAVEL_CYCLES - 1);
  // on arrival the decision is taken at the floor being entered, so search there
  assign probe = !arrive ? floor : state == MOVE_UP ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
  assign decide = state == IDLE || arrive || (state == DOOR && cnt == CW'(DOOR_CYCLES - 1));
  // cnt 0 is the clear cycle, req[floor] is still stale there
  assign restart = state == DOOR && cnt != '0 && here;
  assign ahead = dir_up ? above : below;
  assign behind = dir_up ? below : above;
  assign go_up = ahead ? dir_up : !dir_up;
  buscador_solicitudes u_buscador (.req(req), .floor(probe), .here(here), .above(above), .below(below));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      floor <= '0;
      dir_up <= 1'b1;
      cnt <= '0;
      motor_up <= 1'b0;
      motor_down <= 1'b0;
      door_open <= 1'b0;
      clear <= '0;
    end else begin
      clear <= '0;
      if (arrive) floor <= probe;
      if (restart || (decide && here)) begin
        state <= DOOR;
        cnt <= '0;
        motor_up <= 1'b0;
        motor_down <= 1'b0;
        door_open <= 1'b1;
        clear <= N_FLOORS'(1) << probe;
      end else if (decide && (ahead || behind)) begin
        state <= go_up ? MOVE_UP : MOVE_DOWN;
        dir_up <= go_up;
        cnt <= '0;
        motor_up <= go_up;
        motor_down <= !go_up;
        door_open <= 1'b0;
      end else if (decide) begin
        state <= IDLE;
        cnt <= '0;
        motor_up <= 1'b0;
        motor_down <= 1'b0;
        door_open <= 1'b0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_planificador_ascensor.sv
// tb_planificador_ascensor: directed bench with a request-register model in the loop
module tb_planificador_ascensor;
  logic clk = 1'b0, reset = 1'b0;
  logic [9:0] press = '0, q, req, clear;
  logic [3:0] floor;
  logic motor_up, motor_down, door_open, dir_up;
  int n_chk = 0, n_err = 0;
  int mu_n, md_n, door_n, viol = 0;
  int clr_n[10];
  planificador_ascensor #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk(clk), .reset(reset), .req(req), .floor(floor), .motor_up(motor_up),
    .motor_down(motor_down), .door_open(door_open), .dir_up(dir_up), .clear(clear)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= (q | press) & ~clear;
  assign req = q;
  function automatic logic [9:0] bit_of(input int i);
    return 10'(1) << i;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic zero();
    mu_n = 0; md_n = 0; door_n = 0;
    for (int i = 0; i < 10; i++) clr_n[i] = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    mu_n += int'(motor_up);
    md_n += int'(motor_down);
    door_n += int'(door_open);
    for (int i = 0; i < 10; i++) clr_n[i] += int'(clear[i]);
    if ((motor_up && motor_down) || ((motor_up || motor_down) && door_open) ||
        (motor_up && floor == 4'd9) || (motor_down && floor == 4'd0)) viol++;
  endtask
  task automatic press_tick(input logic [9:0] m);
    press = m;
    tick();
    press = '0;
  endtask
  initial begin
    zero();
    repeat (3) tick();
    check("rst_floor", floor, 0);
    check("rst_dir", dir_up, 1);
    check("rst_outs", {motor_up, motor_down, door_open, clear}, 0);
    reset = 1'b1;
    zero();
    repeat (20) tick();
    check("idle_mu_md_door", mu_n + md_n + door_n, 0);
    check("idle_floor", floor, 0);
    check("idle_dir", dir_up, 1);
    check("idle_clear", clear, 0);
    zero();
    press_tick(bit_of(3));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) check("t2_mu_start", {motor_up, floor}, {1'b1, 4'd0});
      if (k == 5) check("t2_floor1", floor, 1);
      if (k == 9) check("t2_floor2", floor, 2);
      if (k == 12) check("t2_mu_last", {motor_up, floor}, {1'b1, 4'd2});
      if (k == 13) check("t2_arrive", {motor_up, door_open, floor, clear}, {1'b0, 1'b1, 4'd3, bit_of(3)});
      if (k == 19) check("t2_idle", {motor_up, motor_down, door_open}, 0);
    end
    check("t2_mu_n", mu_n, 12);
    check("t2_md_n", md_n, 0);
    check("t2_door_n", door_n, 6);
    check("t2_clr3", clr_n[3], 1);
    zero();
    press_tick(bit_of(5) | bit_of(1));
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) check("t3_up_first", {motor_up, motor_down}, 2'b10);
      if (k == 9) check("t3_at5", {floor, door_open, clear}, {4'd5, 1'b1, bit_of(5)});
      if (k == 15) check("t3_flip", {dir_up, motor_down, floor}, {1'b0, 1'b1, 4'd5});
      if (k == 31) check("t3_at1", {floor, door_open, clear}, {4'd1, 1'b1, bit_of(1)});
      if (k == 37) check("t3_idle", {motor_up, motor_down, door_open}, 0);
    end
    check("t3_mu_n", mu_n, 8);
    check("t3_md_n", md_n, 16);
    check("t3_door_n", door_n, 12);
    check("t3_clr5", clr_n[5], 1);
    check("t3_clr1", clr_n[1], 1);
    check("t3_dir", dir_up, 0);
    zero();
    press_tick(bit_of(1));
    for (int k = 1; k <= 14; k++) begin
      tick();
      press = (k == 4) ? bit_of(1) : '0;
      if (k == 1) check("t4_open", {door_open, clear}, {1'b1, bit_of(1)});
      if (k == 5) check("t4_no_pulse", {door_open, clear}, {1'b1, 10'd0});
      if (k == 6) check("t4_repulse", {door_open, clear}, {1'b1, bit_of(1)});
      if (k == 11) check("t4_still_open", door_open, 1);
      if (k == 12) check("t4_closed", door_open, 0);
    end
    check("t4_door_n", door_n, 11);
    check("t4_clr1", clr_n[1], 2);
    zero();
    press_tick(bit_of(4));
    tick();
    check("t5_moving", {motor_up, dir_up, floor}, {1'b1, 1'b1, 4'd1});
    tick();
    #3 reset = 1'b0;
    #1;
    check("t5_async", {motor_up, motor_down, door_open, clear}, 0);
    check("t5_async_floor", {floor, dir_up}, {4'd0, 1'b1});
    tick();
    reset = 1'b1;
    zero();
    repeat (5) tick();
    check("t5_after", {floor, motor_up, motor_down, door_open}, 0);
    zero();
    press_tick(bit_of(9));
    for (int k = 1; k <= 90; k++) begin
      tick();
      press = (k == 1) ? bit_of(0) : '0;
      if (k == 37) check("t6_at9", {floor, door_open, clear}, {4'd9, 1'b1, bit_of(9)});
      if (k == 43) check("t6_down", {floor, dir_up, motor_down}, {4'd9, 1'b0, 1'b1});
      if (k == 79) check("t6_at0", {floor, door_open, clear}, {4'd0, 1'b1, bit_of(0)});
      if (k == 85) check("t6_idle", {motor_up, motor_down, door_open}, 0);
    end
    check("t6_mu_n", mu_n, 36);
    check("t6_md_n", md_n, 36);
    check("t6_clr9", clr_n[9], 1);
    check("t6_clr0", clr_n[0], 1);
    check("t6_final", {floor, dir_up}, {4'd0, 1'b0});
    check("motor_door_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/planificador_ascensor.md
# planificador_ascensor

Car scheduler for the elevator. Reads the 10-bit pending-request vector held by the request register, runs a directional sweep (keep going while requests lie ahead, reverse otherwise), drives the motor and door, and returns a one-cycle clear pulse so the register drops a request once it is served. Sits between the request register and the motor/door drivers.

## Interface

- N_FLOORS, 10: floors; one request bit per floor.
- TRAVEL_CYCLES, 8: cycles of motor drive per one-floor move; must be ≥ 1.
- DOOR_CYCLES, 16: cycles the door stays open; must be ≥ 2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  N_FLOORS  pending requests from the request register, bit i = floor i.
- floor  out  4  current floor, 0..N_FLOORS-1.
- motor_up  out  1  drive car up.
- motor_down  out  1  drive car down.
- door_open  out  1  door open command.
- dir_up  out  1  sweep direction: 1 = up, 0 = down.
- clear  out  N_FLOORS  one-hot, one-cycle pulse; the register feeds back (Q | new_presses) & ~clear.

## Operation

- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Reset (asynchronous, any state): IDLE, floor=0, dir_up=1, counter=0, all other outputs 0.
- Derived each cycle: here = req[floor]; above = OR of req bits > floor; below = OR of req bits < floor. At floor 9, above=0. At floor 0, below=0.
- Decision rule, used from IDLE, at the end of DOOR, and at each floor arrival:
  - here: enter DOOR and pulse clear[floor].
  - Otherwise, if there is a request ahead in direction dir_up: move in that direction.
  - Otherwise, if there is a request behind: flip dir_up and move that way.
  - Otherwise: IDLE.
- MOVE_UP / MOVE_DOWN:
  - Matching motor output is high for exactly TRAVEL_CYCLES cycles.
  - On the last cycle's edge, floor is incremented or decremented and the decision rule is applied at the new floor.
  - If a request was withdrawn mid-move, the car still completes the floor step.
- DOOR:
  - door_open is high for DOOR_CYCLES cycles.
  - clear[floor] is high in the first DOOR cycle only.
  - From the second cycle on, if here=1 (floor re-pressed), the counter restarts and clear[floor] pulses in the next cycle.
- Motor outputs are never high together. No motor output is high while door_open=1.
- Outputs are registered and decoded from the state/counter registers. They carry no combinational path from req.

## Timing

- IDLE with a request above, sampled at edge t: motor_up=1 from cycle t+1 through t+TRAVEL_CYCLES. floor updates at edge t+TRAVEL_CYCLES.
- Arrival at a requested floor: door_open=1 and clear pulse start in the same cycle, immediately after the final motor cycle. Zero idle gap.
- Request at the current floor while IDLE: door_open=1 one cycle after the sample.
- req[floor] drops one cycle after the clear pulse, as set by the register latency. DOOR therefore ignores req[floor] in the cycle where clear is high.
- Simultaneous above and below with nothing here: current dir_up wins.
- Reset deassertion: first decision at the first rising edge after reset goes high.

## Structure

- Shared package:
  - N_FLOORS and FLOOR_W=4.
  - State enum: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
  - Counter width: clog2 of max(TRAVEL_CYCLES, DOOR_CYCLES).
- Sub-module buscador_solicitudes: combinational (req, floor) → (here, above, below).
- FSM, counter and output registers live in the top module.

## Test plan

Bench uses TRAVEL_CYCLES=4, DOOR_CYCLES=6, with a model of the request register in the loop.

- Reset, then req=0 for 20 cycles: IDLE, floor=0, all outputs 0.
- req=10'b0000001000 (floor 3) from floor 0: motor_up high 12 cycles total. floor steps 1,2,3 at 4-cycle intervals. door_open 6 cycles. clear=10'b0000001000 for one cycle. Then IDLE.
- At floor 3 moving up, with floors 5 and 1 pending:
  - Car serves 5 first, then flips dir_up to 0 and serves 1.
  - Each floor is cleared exactly once.
- Floor re-pressed in DOOR cycle 4: door stays open 6 more cycles from the restart, with a second clear pulse.
- reset asserted in the middle of a MOVE_UP cycle: all outputs 0 within the same cycle (asynchronous). floor=0 after release.
- Requests at floors 9 and 0 only, car at 9: DOOR at 9. Then the car sweeps down to 0. motor_up is never high at floor 9 and motor_down is never high at floor 0.
